// File: rtl/bilinear_pkg.sv
// Shared widths, weight unit and complement-weight helper for the bilinear interpolator.
package bilinear_pkg;

   localparam int unsigned DEF_PIX_W  = 8;
   localparam int unsigned DEF_FRAC_W = 6;
   localparam int unsigned ONE        = 1 << DEF_FRAC_W;
   localparam int unsigned HSUM_W     = DEF_PIX_W + DEF_FRAC_W;
   localparam int unsigned ACC_W      = DEF_PIX_W + 2 * DEF_FRAC_W;

   // Weight of the near sample: 2^frac_w - f.
   function automatic int unsigned comp_weight(input int unsigned f, input int unsigned frac_w);
      return (32'd1 << frac_w) - f;
   endfunction

endpackage

// File: rtl/interp_lerp1d.sv
// One-dimensional linear blend a*(ONE-f) + b*f, registered behind an enable.
module interp_lerp1d
   import bilinear_pkg::*;
#(
   parameter int unsigned DW     = DEF_PIX_W,
   parameter int unsigned FRAC_W = DEF_FRAC_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic [DW-1:0]        i_a,
   input  logic [DW-1:0]        i_b,
   input  logic [FRAC_W-1:0]    i_f,
   output logic [DW+FRAC_W-1:0] o_y
);

   localparam int unsigned OW = DW + FRAC_W;

   logic [FRAC_W:0] w_wc;
   logic [OW-1:0]   w_sum;
   logic [OW-1:0]   r_y;

   assign w_wc = (FRAC_W + 1)'(comp_weight(32'(i_f), FRAC_W));

   // Weights sum to ONE, so the blend never exceeds (2^DW-1)*ONE and fits OW bits.
   assign w_sum = OW'(i_a) * OW'(w_wc) + OW'(i_b) * OW'(i_f);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_y <= '0;
      end else if (i_en) begin
         r_y <= w_sum;
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/bilinear_interp.sv
// Four-stage stallable bilinear interpolator with SOF/EOL sideband and frame counter.
// Define BILINEAR_ROUND_EN for round-half-up output instead of truncation.
module bilinear_interp
   import bilinear_pkg::*;
#(
   parameter int unsigned PIX_W  = DEF_PIX_W,
   parameter int unsigned FRAC_W = DEF_FRAC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic [PIX_W-1:0]  s_lu,
   input  logic [PIX_W-1:0]  s_ru,
   input  logic [PIX_W-1:0]  s_ld,
   input  logic [PIX_W-1:0]  s_rd,
   input  logic [FRAC_W-1:0] s_xfrac,
   input  logic [FRAC_W-1:0] s_yfrac,
   input  logic              s_tuser,
   input  logic              s_tlast,
   output logic [PIX_W-1:0]  m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tuser,
   output logic              m_tlast,
   output logic [15:0]       frame_cnt,
   output logic              busy
);

   localparam int unsigned HW = PIX_W + FRAC_W;
   localparam int unsigned AW = PIX_W + 2 * FRAC_W;

`ifdef BILINEAR_ROUND_EN
   localparam logic [AW-1:0] RND = AW'(1) << (2 * FRAC_W - 1);
`else
   localparam logic [AW-1:0] RND = '0;
`endif

   logic              w_en;
   logic              r_v1, r_v2, r_v3, r_v4;
   logic [PIX_W-1:0]  r_lu1, r_ru1, r_ld1, r_rd1;
   logic [FRAC_W-1:0] r_xf1, r_yf1, r_yf2;
   logic              r_user1, r_user2, r_user3, r_user4;
   logic              r_last1, r_last2, r_last3, r_last4;
   logic [HW-1:0]     w_top, w_bot;
   logic [AW-1:0]     w_acc;
   logic [PIX_W-1:0]  r_data;
   logic [15:0]       r_fcnt;
   logic              r_sof_seen;

   assign w_en     = !r_v4 || m_tready;
   assign s_tready = w_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_v4    <= 1'b0;
         r_lu1   <= '0;
         r_ru1   <= '0;
         r_ld1   <= '0;
         r_rd1   <= '0;
         r_xf1   <= '0;
         r_yf1   <= '0;
         r_yf2   <= '0;
         r_user1 <= 1'b0;
         r_user2 <= 1'b0;
         r_user3 <= 1'b0;
         r_user4 <= 1'b0;
         r_last1 <= 1'b0;
         r_last2 <= 1'b0;
         r_last3 <= 1'b0;
         r_last4 <= 1'b0;
         r_data  <= '0;
      end else if (w_en) begin
         r_v1    <= s_tvalid;
         r_lu1   <= s_lu;
         r_ru1   <= s_ru;
         r_ld1   <= s_ld;
         r_rd1   <= s_rd;
         r_xf1   <= s_xfrac;
         r_yf1   <= s_yfrac;
         r_user1 <= s_tuser;
         r_last1 <= s_tlast;
         r_v2    <= r_v1;
         r_yf2   <= r_yf1;
         r_user2 <= r_user1;
         r_last2 <= r_last1;
         r_v3    <= r_v2;
         r_user3 <= r_user2;
         r_last3 <= r_last2;
         r_v4    <= r_v3;
         r_user4 <= r_user3;
         r_last4 <= r_last3;
         r_data  <= PIX_W'((w_acc + RND) >> (2 * FRAC_W));
      end
   end

   interp_lerp1d #(.DW(PIX_W), .FRAC_W(FRAC_W)) u_lerp_top (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_en),
      .i_a  (r_lu1),
      .i_b  (r_ru1),
      .i_f  (r_xf1),
      .o_y  (w_top)
   );

   interp_lerp1d #(.DW(PIX_W), .FRAC_W(FRAC_W)) u_lerp_bot (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_en),
      .i_a  (r_ld1),
      .i_b  (r_rd1),
      .i_f  (r_xf1),
      .o_y  (w_bot)
   );

   interp_lerp1d #(.DW(HW), .FRAC_W(FRAC_W)) u_lerp_vert (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_en),
      .i_a  (w_top),
      .i_b  (w_bot),
      .i_f  (r_yf2),
      .o_y  (w_acc)
   );

   // The first SOF after reset opens a frame; each later SOF closes the previous one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fcnt     <= '0;
         r_sof_seen <= 1'b0;
      end else if (r_v4 && m_tready && r_user4) begin
         if (r_sof_seen) begin
            r_fcnt <= r_fcnt + 16'd1;
         end
         r_sof_seen <= 1'b1;
      end
   end

   assign m_tdata   = r_data;
   assign m_tvalid  = r_v4;
   assign m_tuser   = r_user4;
   assign m_tlast   = r_last4;
   assign frame_cnt = r_fcnt;
   assign busy      = r_v1 | r_v2 | r_v3 | r_v4;

endmodule

// File: tb/tb_bilinear_interp.sv
// Bench for bilinear_interp: closed-form bilinear model on a scoreboard queue plus directed literals.
module tb_bilinear_interp;

   localparam int PIX_W  = 8;
   localparam int FRAC_W = 6;
   localparam int ONE_W  = 1 << FRAC_W;
`ifdef BILINEAR_ROUND_EN
   localparam int RND_ADD = 1 << (2 * FRAC_W - 1);
`else
   localparam int RND_ADD = 0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_tvalid = 1'b0;
   logic              s_tready;
   logic [PIX_W-1:0]  s_lu = '0, s_ru = '0, s_ld = '0, s_rd = '0;
   logic [FRAC_W-1:0] s_xfrac = '0, s_yfrac = '0;
   logic              s_tuser = 1'b0, s_tlast = 1'b0;
   logic [PIX_W-1:0]  m_tdata;
   logic              m_tvalid;
   logic              m_tready = 1'b1;
   logic              m_tuser, m_tlast;
   logic [15:0]       frame_cnt;
   logic              busy;

   bilinear_interp #(.PIX_W(PIX_W), .FRAC_W(FRAC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_lu      (s_lu),
      .s_ru      (s_ru),
      .s_ld      (s_ld),
      .s_rd      (s_rd),
      .s_xfrac   (s_xfrac),
      .s_yfrac   (s_yfrac),
      .s_tuser   (s_tuser),
      .s_tlast   (s_tlast),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tuser   (m_tuser),
      .m_tlast   (m_tlast),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int d;
      bit u;
      bit l;
   } beat_t;

   beat_t q[$];
   int    n_checks = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    model_fc = 0;
   bit    model_sof_seen = 0;
   bit    bp_mode = 0;
   bit    max_mode = 0;
   int    max_hits = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Closed-form weighted sum of the four corners; weights multiply out to ONE^2.
   function automatic int model_pix(input int lu, input int ru, input int ld, input int rd,
                                    input int x, input int y);
      int s;
      s = lu * (ONE_W - x) * (ONE_W - y) + ru * x * (ONE_W - y)
        + ld * (ONE_W - x) * y + rd * x * y + RND_ADD;
      return s >> (2 * FRAC_W);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Backpressure pattern 1,0,0,1 repeating.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      end
   end

   // Scoreboard / compare process.
   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         q.delete();
         model_fc = 0;
         model_sof_seen = 0;
      end else begin
         chk("s_tready", s_tready, !(m_tvalid && !m_tready));
         chk("busy", busy, q.size() != 0);
         chk("frame_cnt", frame_cnt, model_fc);
         if (m_tvalid && m_tready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               b = q.pop_front();
               chk("m_tdata", m_tdata, b.d);
               chk("m_tuser", m_tuser, b.u);
               chk("m_tlast", m_tlast, b.l);
               if (m_tuser) begin
                  if (model_sof_seen) model_fc = (model_fc + 1) % 65536;
                  model_sof_seen = 1;
               end
               if (max_mode && m_tdata == 8'd255) max_hits++;
            end
         end
         if (s_tvalid && s_tready) begin
            b.d = model_pix(s_lu, s_ru, s_ld, s_rd, s_xfrac, s_yfrac);
            b.u = s_tuser;
            b.l = s_tlast;
            q.push_back(b);
         end
      end
   end

   task automatic send_beat(input int lu, input int ru, input int ld, input int rd,
                            input int x, input int y, input bit u, input bit l);
      bit ok;
      s_lu = PIX_W'(lu); s_ru = PIX_W'(ru); s_ld = PIX_W'(ld); s_rd = PIX_W'(rd);
      s_xfrac = FRAC_W'(x); s_yfrac = FRAC_W'(y);
      s_tuser = u; s_tlast = l;
      s_tvalid = 1'b1;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tuser = 1'b0;
      s_tlast = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 300; t++) begin
         if (q.size() == 0 && !busy) break;
         @(posedge clk);
         #1;
      end
      chk("drain_queue_empty", q.size(), 0);
   endtask

   // Single beat with literal result and 4-cycle latency check.
   task automatic single_literal(input string name, input int lu, input int ru, input int ld,
                                 input int rd, input int x, input int y, input int exp);
      int lat;
      bit seen;
      send_beat(lu, ru, ld, rd, x, y, 0, 0);
      lat = 0;
      seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         lat++;
         if (m_tvalid) seen = 1;
      end
      chk({name, "_latency"}, seen ? lat : -1, 4);
      chk({name, "_data"}, m_tdata, exp);
      wait_drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tuser", m_tuser, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_tready", s_tready, 1);
      @(posedge clk);
      #1;

      // Corner weights and midpoint.
      single_literal("corner00", 10, 20, 30, 40, 0, 0, 10);
`ifdef BILINEAR_ROUND_EN
      single_literal("corner6363", 10, 20, 30, 40, 63, 63, 40);
      single_literal("midpoint", 0, 255, 0, 255, 32, 32, 128);
`else
      single_literal("corner6363", 10, 20, 30, 40, 63, 63, 39);
      single_literal("midpoint", 0, 255, 0, 255, 32, 32, 127);
`endif
      single_literal("full_x", 10, 20, 30, 40, 32, 0, 15);

      // Max value with random fractions.
      max_mode = 1;
      for (int i = 0; i < 1000; i++)
         send_beat(255, 255, 255, 255, $urandom_range(0, ONE_W - 1), $urandom_range(0, ONE_W - 1), 0, 0);
      wait_drain();
      max_mode = 0;
      chk("max_all_255", max_hits, 1000);

      // Backpressure.
      bp_mode = 1;
      for (int i = 0; i < 20; i++)
         send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, ONE_W - 1),
                   $urandom_range(0, ONE_W - 1), 0, 0);
      repeat (8) @(posedge clk);
      #1;
      bp_mode = 0;
      m_tready = 1'b1;
      wait_drain();

      // Sideband: 3 frames of 4 lines x 16 pixels.
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 64; i++)
            send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, ONE_W - 1),
                      $urandom_range(0, ONE_W - 1), i == 0, (i % 16) == 15);
      wait_drain();
      chk("frame_cnt_after_3_sof", frame_cnt, 2);

      // Reset with three beats in flight.
      send_beat(1, 2, 3, 4, 5, 6, 1, 0);
      send_beat(7, 8, 9, 10, 11, 12, 0, 0);
      send_beat(13, 14, 15, 16, 17, 18, 0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_m_tvalid", m_tvalid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      chk("midrst_s_tready", s_tready, 1);
      repeat (10) @(posedge clk);
      #1;
      single_literal("post_rst_beat", 10, 20, 30, 40, 0, 0, 10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/bilinear_interp.md
Name: bilinear_interp

Overview:
Consumes the four neighbouring source pixels (lu, ru, ld, rd) from the rectification fetch stage, together with the fractional part of the remapped coordinate, and produces one bilinearly interpolated output pixel. It is the stage directly downstream of the line-buffer fetch. It is a fully pipelined, stallable AXI-Stream-style datapath that carries frame sideband (SOF/EOL) alongside the data.

Parameters:
- PIX_W, 8, pixel width in bits.
- FRAC_W, 6, width of the fractional x/y coordinate; weight unit ONE = 2^FRAC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when s_tvalid && s_tready.
- s_lu, s_ru, s_ld, s_rd  in  PIX_W each  neighbour pixels, in order: up-left, up-right, down-left, down-right.
- s_xfrac, s_yfrac  in  FRAC_W each  fractional offsets, 0..ONE-1.
- s_tuser  in  1  start of frame (first pixel).
- s_tlast  in  1  last pixel of a line.
- m_tdata  out  PIX_W  interpolated pixel.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tuser, m_tlast  out  1 each  delayed copies of s_tuser and s_tlast.
- frame_cnt  out  16  count of completed frames.
- busy  out  1  high while any pipeline stage holds a valid beat.

Behaviour:
- Reset values: all stage valids 0, m_tvalid 0, m_tdata 0, m_tuser 0, m_tlast 0, frame_cnt 0, busy 0.
- Global pipeline enable: en = !m_tvalid || m_tready. s_tready = en, purely combinational. When en = 0, every stage holds its contents, including the valid bits and sideband.
- Pipeline stages, all advancing on en:
  - S1: register the inputs, the sideband, and v1 = s_tvalid && s_tready.
  - S2: wx = ONE - xfrac (FRAC_W+1 bits). top = lu*wx + ru*xfrac. bot = ld*wx + rd*xfrac. Both are PIX_W+FRAC_W bits unsigned. Carry wy = ONE - yfrac and yfrac forward.
  - S3: acc = top*wy + bot*yfrac, PIX_W+2*FRAC_W bits.
  - S4: m_tdata = acc >> (2*FRAC_W), plus the rounding term described under Optional Feature.
- Latency: 4 cycles from input handshake to m_tvalid when not stalled. Throughput is 1 pixel per clock.
- No saturation is needed: because the weights sum exactly to ONE^2, the result is ≤ 2^PIX_W - 1 by construction. The verifier asserts this.
- Bubbles (s_tvalid = 0) propagate as invalid slots. Invalid slots do not raise m_tvalid, but they still advance when en = 1.
- Sideband tuser and tlast travel with their beat and are never reordered.
- frame_cnt increments on each output handshake where m_tuser = 1, excluding the very first after reset (a new frame implies the previous frame completed). It wraps at 2^16.
- busy = v1 | v2 | v3 | m_tvalid.
- Reset mid-operation: all in-flight beats are discarded and frame_cnt is cleared. s_tready is 1 in the cycle after reset deasserts.
- Simultaneous m_tready = 0 and s_tvalid = 1 with m_tvalid = 1: the input is not accepted, and upstream must hold its beat.

Optional Feature:
- Macro BILINEAR_ROUND_EN.
  - Defined: S4 adds 2^(2*FRAC_W-1) before the shift (round half up).
  - Undefined: plain truncation.
- Timing and latency are identical in both builds.

Decomposition:
- Package bilinear_pkg holds:
  - PIX_W and FRAC_W defaults.
  - ONE.
  - ACC_W = PIX_W + 2*FRAC_W.
  - HSUM_W = PIX_W + FRAC_W.
  - A function computing the complement weight.
- One sub-module, interp_lerp1d: parameterized by data width. It computes a*(ONE-f) + b*f as a registered, enable-gated output. It is instantiated twice in S2 (top, bot) and once in S3.

Test Plan:
- Corner weights: lu=10, ru=20, ld=30, rd=40 with xfrac=0, yfrac=0 → m_tdata=10. With xfrac=0, yfrac=0 and lu=0 set aside, use xfrac=63, yfrac=63 (FRAC_W=6) → truncate gives 39; with BILINEAR_ROUND_EN → 40. Latency is exactly 4 cycles.
- Midpoint: all four pixels 0/255/0/255, xfrac=32, yfrac=32 → truncate 127; rounded 128.
- Max value: all four pixels 255, random fractions over 1000 beats → m_tdata always 255, no overflow.
- Backpressure: stream 20 beats with m_tready toggling 1,0,0,1 repeatedly → output sequence matches the reference model, with no drops or duplicates, and s_tready = 0 exactly when m_tvalid && !m_tready.
- Sideband: 3 frames of 4×16 pixels with tuser on pixel 0 and tlast every 16th pixel → m_tuser/m_tlast on the same beats, and frame_cnt = 2 after the third SOF output.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → m_tvalid=0, busy=0, frame_cnt=0 the next cycle, and no stale beats appear afterwards.
